// File: rtl/bch_chien_search.sv
// bch_chien_search
//   Chien search over GF(2^M) for a binary BCH decoder. A locator polynomial
//   Lambda(x) = sum_j sigma_j * x^j is loaded on an accepted start. The block
//   then evaluates Lambda(alpha^(k+1)) for k = 0 .. DATA_BITS-1, one position
//   per clock. A zero result flags data bit k (codeword MSB first) as in error.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   start      load request; accepted only while ready is high
//   sigma      locator coefficients, coefficient j at sigma[j*M +: M]
//   ready      high in IDLE (including the cycle that carries last)
//   valid      err_bit / first / last are meaningful this cycle
//   err_bit    current data bit is in error
//   first      marks data bit 0
//   last       marks data bit DATA_BITS-1
//   err_count  running count of flagged bits, saturating at T+1
//   fail       sticky per search: sigma_0 == 0, or more than T flagged bits
//
// Handshake: start is sampled on a rising edge while ready is high. Starts
// that arrive while ready is low are dropped and do not disturb the search.
module bch_chien_search #(
  parameter int M         = 4,
  parameter int T         = 3,
  parameter int DATA_BITS = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [M*(T+1)-1:0]     sigma,
  output logic                   ready,
  output logic                   valid,
  output logic                   err_bit,
  output logic                   first,
  output logic                   last,
  output logic [$clog2(T+1):0]   err_count,
  output logic                   fail
);

  localparam int CW = $clog2(T+1) + 1;
  localparam int PW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  // Primitive polynomials shared with the rest of the BCH codebase.
  function automatic logic [15:0] prim_poly(input int m);
    case (m)
      3:       prim_poly = 16'h000B;
      4:       prim_poly = 16'h0013;
      5:       prim_poly = 16'h0025;
      6:       prim_poly = 16'h0043;
      7:       prim_poly = 16'h0089;
      8:       prim_poly = 16'h011D;
      9:       prim_poly = 16'h0211;
      10:      prim_poly = 16'h0409;
      default: prim_poly = 16'h0013;
    endcase
  endfunction

  localparam logic [15:0]  POLY_FULL = prim_poly(M);
  localparam logic [M-1:0] POLY_LOW  = POLY_FULL[M-1:0];

  function automatic logic [M-1:0] mul_alpha(input logic [M-1:0] x);
    mul_alpha = {x[M-2:0], 1'b0} ^ (x[M-1] ? POLY_LOW : '0);
  endfunction

  // Multiply by alpha^p. p is a constant at every call site, so this unrolls
  // into a fixed XOR network.
  function automatic logic [M-1:0] mul_alpha_pow(input logic [M-1:0] x, input int p);
    logic [M-1:0] r;
    r = x;
    for (int i = 1; i <= T; i++) begin
      if (i <= p) r = mul_alpha(r);
    end
    mul_alpha_pow = r;
  endfunction

  typedef enum logic {S_IDLE = 1'b0, S_SEARCH = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [M-1:0]    term_q [0:T];
  logic [M-1:0]    term_d [0:T];
  logic [PW-1:0]   pos_q, pos_d;
  logic            valid_q, valid_d;
  logic            err_bit_q, err_bit_d;
  logic            first_q, first_d;
  logic            last_q, last_d;
  logic [CW-1:0]   count_q, count_d;
  logic            fail_q, fail_d;

  logic            load;
  logic            step;
  logic            pos_last;
  logic [M-1:0]    sum;
  logic            s0_zero;
  logic            hit;

  assign pos_last = (pos_q == PW'(DATA_BITS - 1));

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start)    state_d = S_SEARCH;
      S_SEARCH: if (pos_last) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    ready = (state_q == S_IDLE);
    load  = (state_q == S_IDLE) && start;
    step  = (state_q == S_SEARCH);
  end

  // Parallel XOR of all terms is Lambda at the current evaluation point.
  // Register 0 holds sigma_0 unchanged, so it doubles as the sigma_0 == 0 flag.
  always_comb begin
    sum = '0;
    for (int j = 0; j <= T; j++) sum = sum ^ term_q[j];
    s0_zero = (term_q[0] == '0);
    hit     = (sum == '0) && !s0_zero;
  end

  always_comb begin
    for (int j = 0; j <= T; j++) term_d[j] = term_q[j];
    pos_d     = pos_q;
    valid_d   = 1'b0;
    err_bit_d = 1'b0;
    first_d   = 1'b0;
    last_d    = 1'b0;
    count_d   = count_q;
    fail_d    = fail_q;
    if (load) begin
      for (int j = 0; j <= T; j++) term_d[j] = mul_alpha_pow(sigma[j*M +: M], j);
      pos_d   = '0;
      count_d = '0;
      fail_d  = 1'b0;
    end else if (step) begin
      for (int j = 1; j <= T; j++) term_d[j] = mul_alpha_pow(term_q[j], j);
      if (!pos_last) pos_d = pos_q + 1'b1;
      valid_d   = 1'b1;
      err_bit_d = hit;
      first_d   = (pos_q == '0);
      last_d    = pos_last;
      if (hit) begin
        if (count_q != CW'(T + 1)) count_d = count_q + 1'b1;
        if (count_q >= CW'(T))     fail_d  = 1'b1;
      end
      if (s0_zero) fail_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j <= T; j++) term_q[j] <= '0;
      pos_q     <= '0;
      valid_q   <= 1'b0;
      err_bit_q <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      count_q   <= '0;
      fail_q    <= 1'b0;
    end else begin
      for (int j = 0; j <= T; j++) term_q[j] <= term_d[j];
      pos_q     <= pos_d;
      valid_q   <= valid_d;
      err_bit_q <= err_bit_d;
      first_q   <= first_d;
      last_q    <= last_d;
      count_q   <= count_d;
      fail_q    <= fail_d;
    end
  end

  assign valid     = valid_q;
  assign err_bit   = err_bit_q;
  assign first     = first_q;
  assign last      = last_q;
  assign err_count = count_q;
  assign fail      = fail_q;

endmodule

// File: tb/tb_bch_chien_search.sv
// tb_bch_chien_search
//   Self-checking bench for bch_chien_search at M=4, T=3, DATA_BITS=5.
//   Expected outputs come from a log/antilog GF(16) model that evaluates
//   Lambda(alpha^(k+1)) directly for each data bit.
module tb_bch_chien_search;

  localparam int M  = 4;
  localparam int T  = 3;
  localparam int DB = 5;
  localparam int SW = M * (T + 1);
  localparam int CW = $clog2(T + 1) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [SW-1:0] sigma;
  logic          ready, valid, err_bit, first, last, fail;
  logic [CW-1:0] err_count;

  bch_chien_search #(.M(M), .T(T), .DATA_BITS(DB)) dut (
    .clk(clk), .reset(reset), .start(start), .sigma(sigma),
    .ready(ready), .valid(valid), .err_bit(err_bit), .first(first),
    .last(last), .err_count(err_count), .fail(fail)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int gexp [0:14];
  int glog [0:15];

  // Packed observation: {valid, err_bit, first, last, err_count[2:0], fail}
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         obs_lat;
  bit         obs_to;
  logic       obs_after;

  function automatic logic [7:0] pack_now();
    return {valid, err_bit, first, last, err_count, fail};
  endfunction

  function automatic void build_tables();
    int v;
    v = 1;
    for (int i = 0; i < 15; i++) begin
      gexp[i] = v;
      glog[v] = i;
      v = v << 1;
      if ((v & 16) != 0) v = v ^ 19;
    end
  endfunction

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return gexp[(glog[a] + glog[b]) % 15];
  endfunction

  function automatic int coef(input logic [SW-1:0] s, input int j);
    logic [SW-1:0] t;
    t = s >> (j * M);
    return int'(t[M-1:0]);
  endfunction

  function automatic int lambda_at(input logic [SW-1:0] s, input int e);
    int acc;
    acc = 0;
    for (int j = 0; j <= T; j++) acc = acc ^ gmul(coef(s, j), gexp[(j * e) % 15]);
    return acc;
  endfunction

  function automatic void build_expected(input logic [SW-1:0] s);
    int  cnt;
    bit  f, root;
    logic [2:0] c3;
    exp_q.delete();
    cnt = 0;
    f   = (coef(s, 0) == 0);
    for (int k = 0; k < DB; k++) begin
      root = (coef(s, 0) != 0) && (lambda_at(s, k + 1) == 0);
      if (root) begin
        if (cnt >= T) f = 1'b1;
        if (cnt < T + 1) cnt++;
      end
      c3 = 3'(cnt);
      exp_q.push_back({1'b1, root, (k == 0), (k == DB - 1), c3, f});
    end
  endfunction

  // Lambda = scale * prod over chosen k of (x + alpha^(k+1))
  function automatic logic [SW-1:0] poly_from_roots(input int mask, input int scale);
    int c [0:T];
    int n [0:T];
    int r;
    logic [SW-1:0] s;
    for (int j = 0; j <= T; j++) c[j] = 0;
    c[0] = scale;
    for (int k = 0; k < DB; k++) begin
      if (((mask >> k) & 1) != 0) begin
        r = gexp[k + 1];
        for (int j = 0; j <= T; j++) n[j] = gmul(c[j], r) ^ ((j > 0) ? c[j-1] : 0);
        for (int j = 0; j <= T; j++) c[j] = n[j];
      end
    end
    s = '0;
    for (int j = 0; j <= T; j++) s = s | (SW'(c[j]) << (j * M));
    return s;
  endfunction

  task automatic drive_start(input logic [SW-1:0] s);
    @(negedge clk);
    sigma = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sigma = SW'($urandom);
  endtask

  task automatic capture();
    obs_q.delete();
    obs_to  = 1'b0;
    obs_lat = 0;
    forever begin
      @(posedge clk);
      #1;
      obs_lat++;
      if (valid) break;
      if (obs_lat > 20) begin
        obs_to = 1'b1;
        return;
      end
    end
    obs_q.push_back(pack_now());
    for (int k = 1; k < DB; k++) begin
      @(posedge clk);
      #1;
      obs_q.push_back(pack_now());
    end
    @(posedge clk);
    #1;
    obs_after = valid;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    sigma = '0;
    #12;
    checks++;
    if ({ready, valid, err_bit, first, last, err_count, fail} !== 9'b1_0000_000_0) begin
      errors++;
      $display("FAIL reset_state got %b exp %b",
               {ready, valid, err_bit, first, last, err_count, fail}, 9'b1_0000_000_0);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset ready=%b valid=%b exp ready=1 valid=0", ready, valid);
    end
  endtask

  task automatic run_and_compare(input string name, input logic [SW-1:0] s);
    build_expected(s);
    drive_start(s);
    capture();
    checks++;
    if (obs_to) begin
      errors++;
      $display("FAIL %s timeout waiting for valid", name);
      return;
    end
    checks++;
    if (obs_lat !== 1) begin
      errors++;
      $display("FAIL %s latency got %0d exp 1", name, obs_lat);
    end
    for (int k = 0; k < DB; k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL %s bit%0d got %b exp %b", name, k, obs_q[k], exp_q[k]);
      end
    end
    checks++;
    if (obs_after !== 1'b0) begin
      errors++;
      $display("FAIL %s valid_after_last got %b exp 0", name, obs_after);
    end
  endtask

  task automatic test_no_errors();
    run_and_compare("no_errors", 16'h0001);
    // Final count and fail hold in IDLE.
    @(negedge clk);
    checks++;
    if (err_count !== 3'd0 || fail !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL no_errors_hold cnt=%0d fail=%b valid=%b exp 0 0 0", err_count, fail, valid);
    end
  endtask

  task automatic test_single_error();
    run_and_compare("single_error", 16'h00F1);
    checks++;
    if (obs_q.size() == DB && obs_q[2][6] !== 1'b1) begin
      errors++;
      $display("FAIL single_error_bit2 got %b exp 1", obs_q[2][6]);
    end
    @(negedge clk);
    checks++;
    if (err_count !== 3'd1 || fail !== 1'b0) begin
      errors++;
      $display("FAIL single_error_hold cnt=%0d fail=%b exp 1 0", err_count, fail);
    end
  endtask

  task automatic test_sigma0_zero();
    logic [SW-1:0] s;
    for (int i = 0; i < 3; i++) begin
      s = SW'($urandom);
      s[M-1:0] = '0;
      run_and_compare("sigma0_zero", s);
    end
  endtask

  task automatic test_random_roots();
    int mask, nroots, scale;
    logic [SW-1:0] s;
    for (int i = 0; i < 10; i++) begin
      do begin
        mask   = $urandom_range(1, 31);
        nroots = $countones(mask);
      end while (nroots > T);
      scale = $urandom_range(1, 15);
      s = poly_from_roots(mask, scale);
      run_and_compare("random_roots", s);
      checks++;
      if (obs_q.size() == DB && int'(obs_q[DB-1][3:1]) != nroots) begin
        errors++;
        $display("FAIL random_roots_count mask=%b got %0d exp %0d", mask[4:0], obs_q[DB-1][3:1], nroots);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [SW-1:0] plan [0:3];
    plan[0] = 16'h00F1;
    plan[1] = 16'h0001;
    plan[2] = poly_from_roots(5'b10101, 7);
    plan[3] = 16'h00F1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sigma = plan[i];
      start = 1'b1;
      build_expected(plan[i]);
      @(posedge clk);
      #1;
      checks++;
      if (valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b_gap search%0d valid got %b exp 0", i, valid);
      end
      for (int k = 0; k < DB; k++) begin
        @(negedge clk);
        sigma = SW'($urandom);
        @(posedge clk);
        #1;
        checks++;
        if (pack_now() !== exp_q[k]) begin
          errors++;
          $display("FAIL b2b search%0d bit%0d got %b exp %b", i, k, pack_now(), exp_q[k]);
        end
        checks++;
        if (ready !== (k == DB - 1)) begin
          errors++;
          $display("FAIL b2b_ready search%0d bit%0d got %b exp %b", i, k, ready, (k == DB - 1));
        end
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [SW-1:0] s;
    s = poly_from_roots(5'b01010, 3);
    build_expected(s);
    drive_start(s);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (pack_now() !== exp_q[3]) begin
      errors++;
      $display("FAIL reset_mid_bit3 got %b exp %b", pack_now(), exp_q[3]);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({ready, valid, err_bit, first, last, err_count, fail} !== 9'b1_0000_000_0) begin
      errors++;
      $display("FAIL reset_mid_async got %b exp %b",
               {ready, valid, err_bit, first, last, err_count, fail}, 9'b1_0000_000_0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_hold valid got %b exp 0", valid);
    end
    @(negedge clk);
    reset = 1'b0;
    run_and_compare("after_reset", poly_from_roots(5'b00110, 9));
  endtask

  initial begin
    build_tables();
    test_reset();
    test_no_errors();
    test_single_error();
    test_sigma0_zero();
    test_random_roots();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
